// File: rtl/alu_seq.sv
// Sequential ALU stage feeding the accumulator (result -> ACin, wr_AC strobe).
// Optional build macro ALU_MUL_EN: op 111 is a multi-cycle shift-add multiply; otherwise SHR1.
module alu_seq #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             wr_AC,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

`ifdef ALU_MUL_EN
    localparam logic [2:0]  OP_MUL = 3'b111;
    localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;
`else
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     psum;
    logic [CW-1:0]      cnt;
    logic               mul_last;
    logic               ovf_q;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef ALU_MUL_EN
    assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_nxt = S_EXEC;
`endif
                end
            end
            S_EXEC: state_nxt = S_DONE;
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign wr_AC = (state == S_DONE);

    // ------------------------------------------------------------------
    // Single-cycle operations on the latched operands
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            // Extending to WIDTH+1 bits makes the top bit the unsigned borrow.
            OP_SUB: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
`ifndef ALU_MUL_EN
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
`endif
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // Multiplier sits in the low half of prod and shifts out as the product fills the top.
    always_comb begin
        psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_q} : '0);
        prod_nxt = {psum, prod[WIDTH-1:1]};
    end
`endif

    // ------------------------------------------------------------------
    // Operand latches, multiply datapath and registered result/flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
`ifdef ALU_MUL_EN
            prod   <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= opa;
                        b_q  <= opb;
`ifdef ALU_MUL_EN
                        prod <= {{WIDTH{1'b0}}, opa};
                        cnt  <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    neg    <= alu_res[WIDTH-1];
                    carry  <= alu_c;
`ifdef ALU_MUL_EN
                    ovf_q  <= 1'b0;
`endif
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CW'(1);
                    if (mul_last) begin
                        result <= prod_nxt[WIDTH-1:0];
                        zero   <= (prod_nxt[WIDTH-1:0] == '0);
                        neg    <= prod_nxt[WIDTH-1];
                        carry  <= 1'b0;
                        ovf_q  <= |prod_nxt[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_MUL_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan cases plus random ops against an arithmetic model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;

    localparam int unsigned W = 18;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic         wr_AC;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;

    int unsigned vectors;
    int unsigned miscompares;

    // Last values that should be visible on the flag/result outputs.
    logic [W-1:0] p_res;
    logic         p_z, p_n, p_c, p_v;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .wr_AC  (wr_AC),
        .result (result),
        .zero   (zero),
        .neg    (neg),
        .carry  (carry),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint unsigned x = 64'(a);
        longint unsigned y = 64'(b);
        longint unsigned m = (64'd1 << W) - 1;
        longint unsigned f = 0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin f = x + y; c = (f > m); end
            3'd1: begin f = x - y; c = (x < y); end
            3'd2: f = x & y;
            3'd3: f = x | y;
            3'd4: f = x ^ y;
            3'd5: f = ~x;
            3'd6: begin f = x * 2; c = (x >= (64'd1 << (W - 1))); end
            default: begin
                if (MUL_EN) begin
                    f = x * y;
                    v = ((f >> W) != 0);
                end else begin
                    f = x / 2;
                    c = (x % 2) == 1;
                end
            end
        endcase
        r = W'(f & m);
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_busy, input bit poke_done);
        logic [W-1:0] er;
        logic         ec, ev;
        int unsigned  lat;
        model(o, a, b, er, ec, ev);
        lat = (MUL_EN && o == 3'd7) ? W + 1 : 2;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = (poke_busy && lat > 2 && k == 2) || (poke_done && k == lat);
            op    = 3'd0;
            opa   = W'($urandom);
            opb   = W'($urandom);
            chk("busy", busy, 1);
            chk("done", done, (k == lat));
            chk("wr_AC", wr_AC, (k == lat));
            if (k < lat) begin
                chk("res_hold", result, p_res);
                chk("carry_hold", carry, p_c);
                chk("ovf_hold", ovf, p_v);
            end
        end
        chk("result", result, er);
        chk("zero", zero, (er == '0));
        chk("neg", neg, er[W-1]);
        chk("carry", carry, ec);
        chk("ovf", ovf, ev);
        @(negedge clk);
        start = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_wr", wr_AC, 0);
        p_res = er;
        p_z   = (er == '0);
        p_n   = er[W-1];
        p_c   = ec;
        p_v   = ev;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        p_res = '0; p_z = 0; p_n = 0; p_c = 0; p_v = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        opa   = '0;
        opb   = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed plan cases
        run_op(3'd0, 18'h3FFFF, 18'h00001, 0, 0);
        run_op(3'd1, 18'd5, 18'd7, 0, 0);
        if (MUL_EN) begin
            run_op(3'd7, 18'd300, 18'd500, 0, 0);
            run_op(3'd7, 18'd1000, 18'd1000, 1, 0);
        end else begin
            run_op(3'd7, 18'h00003, 18'h00000, 0, 0);
            run_op(3'd7, 18'h20000, 18'h12345, 0, 0);
        end
        run_op(3'd2, 18'h3C3C3, 18'h0FF0F, 0, 1);
        run_op(3'd3, 18'h00000, 18'h00000, 0, 0);
        run_op(3'd4, 18'h2AAAA, 18'h15555, 0, 0);
        run_op(3'd5, 18'h00000, 18'h3FFFF, 0, 0);
        run_op(3'd6, 18'h30001, 18'h00000, 0, 0);
        run_op(3'd7, 18'h3FFFF, 18'h3FFFF, 1, 1);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; op = 3'd7; opa = 18'd300; opb = 18'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (MUL_EN ? 4 : 0) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_wr", wr_AC, 0);
        chk("arst_result", result, 0);
        chk("arst_zero", zero, 0);
        chk("arst_neg", neg, 0);
        chk("arst_carry", carry, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(W) + 4; k++) begin
            @(negedge clk);
            chk("abort_done", done, 0);
            chk("abort_wr", wr_AC, 0);
        end
        p_res = '0; p_z = 0; p_n = 0; p_c = 0; p_v = 0;
        run_op(3'd0, 18'd1234, 18'd4321, 0, 0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) rb = W'($urandom_range(0, 3));
            run_op(ro, ra, rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequential ALU stage directly upstream of the accumulator register. It latches an accumulator operand and a memory-data operand on a start pulse and executes one operation. Single-cycle logic ops finish quickly; multiply runs as a multi-cycle shift-add. It then presents the result with a one-cycle write strobe that drives the accumulator's ACin and wr_AC inputs.

Parameters:
WIDTH, 18, datapath width; must match accumulator width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request pulse; sampled only in IDLE.
op  input  3  operation select, latched with start.
opa  input  WIDTH  operand A, the accumulator value.
opb  input  WIDTH  operand B, the memory-data value.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when result is valid.
wr_AC  output  1  one-cycle accumulator write strobe, coincident with done.
result  output  WIDTH  registered result; held until the next done.
zero  output  1  result == 0; updated with done.
neg  output  1  result[WIDTH-1]; updated with done.
carry  output  1  carry, borrow or shifted-out bit; updated with done.
ovf  output  1  multiply overflow; updated with done.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy, done, wr_AC, result, zero, neg, carry, ovf and all internal registers are cleared to 0.
  - Reset asserted mid-operation aborts it; no done or wr_AC is issued.
- States:
  - IDLE: start=1 latches op, opa, opb. Next state is MUL if op=111, otherwise EXEC. With start=0, stay in IDLE.
  - EXEC: compute in one cycle, register result and flags, go to DONE.
  - MUL: WIDTH iterations counted 0..WIDTH-1. Each iteration adds the multiplicand to the 2*WIDTH-bit partial product when the current multiplier bit is 1, then shifts. After the final iteration, go to DONE.
  - DONE: done=1 and wr_AC=1 for exactly this cycle, then return to IDLE.
- Timing, with start accepted in cycle N:
  - busy=1 from N+1 through the done cycle; busy=0 in IDLE.
  - Non-multiply ops: done in N+2.
  - Multiply: done in N+WIDTH+1 (N+19 at default WIDTH).
- Ops:
  - 000 ADD: A+B; carry = bit WIDTH of the sum.
  - 001 SUB: A-B; carry = borrow (1 when A<B unsigned).
  - 010 AND, 011 OR, 100 XOR, 101 NOT A: carry=0.
  - 110 SHL1: result = A<<1; carry = A[WIDTH-1].
  - 111 MUL: unsigned. result = low WIDTH bits of the product; ovf = OR of the high WIDTH bits; carry=0.
- Flags:
  - ovf=0 for all ops other than MUL.
  - zero and neg are derived from the registered result.
  - All flags change only when done is issued.
- Handshake rules:
  - start while busy is ignored; the in-flight op completes unchanged.
  - start in the same cycle as done is ignored; a new start is accepted from the following IDLE cycle.
  - Operand inputs may change freely after the start cycle.
- Width: all arithmetic is modulo 2^WIDTH. No signed interpretation except the neg flag.

Optional Feature:
ALU_MUL_EN:
- Defined: op 111 is the multi-cycle multiply described above.
- Undefined:
  - No multiply hardware, counter or MUL state is built.
  - op 111 becomes SHR1 (logical A>>1, carry = A[0]) through EXEC, with 2-cycle latency.
  - ovf is tied to 0.

Test Plan:
- ADD 18'h3FFFF+18'h00001, start at N -> done/wr_AC at N+2; result 0, zero=1, carry=1, neg=0.
- SUB 5-7 -> result 18'h3FFFE, neg=1, carry=1, zero=0, done at N+2.
- MUL 300*500 (ALU_MUL_EN) -> busy N+1..N+19, done at N+19; result 18'h249F0, ovf=0.
- MUL 1000*1000 -> result 18'h34240, ovf=1. Without ALU_MUL_EN, op 111 on A=18'h00003 -> result 18'h00001, carry=1 at N+2.
- start pulse with op=000 during an in-flight MUL -> ignored. Exactly one done, carrying the MUL result; no extra wr_AC.
- rst asserted at cycle N+5 of a MUL -> all outputs 0 immediately (asynchronous); no done/wr_AC afterwards; a new ADD then completes normally.
